// File: rtl/mist_dump_window.sv
// mist_dump_window: frame-counting dump-window controller driving probe on/off and depth.
module mist_dump_window #(
  parameter int CW = 32,
  parameter int SW = 8,
  parameter logic [15:0] LED_GUARD = 16'd1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          led,
  input  logic [1:0]    cfg_mode,
  input  logic [CW-1:0] cfg_start,
  input  logic [CW-1:0] cfg_len,
  input  logic [CW-1:0] cfg_period,
  input  logic          cfg_deep,
  output logic [CW-1:0] frame_cnt,
  output logic          dumping,
  output logic          dump_on,
  output logic          dump_off,
  output logic          dump_deep,
  output logic [SW-1:0] win_cnt
);
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, DUMPING = 2'd2, DONE = 2'd3;
  localparam logic [CW-1:0] ONE = CW'(1);
  logic [1:0] state, md;
  logic vs_q, led_q, fe_vs, fe_led, trig, close;
  logic [15:0] guard;
  logic [CW-1:0] nxt, len, per, fcnt;
  always_comb begin
    fe_vs = vs_q & ~vs;
    fe_led = led_q & ~led;
    trig = md == 2'd1 ? fe_vs && frame_cnt == nxt : md == 2'd2 ? fe_led && guard >= LED_GUARD : md == 2'd3;
    close = fe_vs && len != '0 && fcnt + ONE == len;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      md <= 2'd0;
      vs_q <= 1'b0;
      led_q <= 1'b0;
      guard <= '0;
      nxt <= '0;
      len <= '0;
      per <= '0;
      fcnt <= '0;
      frame_cnt <= '0;
      dumping <= 1'b0;
      dump_on <= 1'b0;
      dump_off <= 1'b0;
      dump_deep <= 1'b0;
      win_cnt <= '0;
    end else begin
      vs_q <= vs;
      led_q <= led;
      dump_on <= 1'b0;
      dump_off <= 1'b0;
      if (fe_vs) frame_cnt <= frame_cnt + ONE;
      if (guard < LED_GUARD) guard <= guard + 16'd1;
      if (cfg_mode == 2'd0) begin
        dump_off <= state == DUMPING;
        dumping <= 1'b0;
        state <= IDLE;
      end else if (state == IDLE) begin
        state <= ARMED;
        md <= cfg_mode;
        nxt <= cfg_start;
        len <= cfg_len;
        per <= cfg_period != '0 && cfg_period <= cfg_len ? '0 : cfg_period;
      end else if (state == ARMED && trig) begin
        state <= DUMPING;
        dump_on <= 1'b1;
        dumping <= 1'b1;
        dump_deep <= cfg_deep;
        fcnt <= '0;
      end else if (state == DUMPING && close) begin
        dump_off <= 1'b1;
        dumping <= 1'b0;
        win_cnt <= &win_cnt ? win_cnt : win_cnt + SW'(1);
        // periodic re-arm always triggers by frame match, whatever the original mode
        if (per != '0) begin
          nxt <= nxt + per;
          md <= 2'd1;
          state <= ARMED;
        end else begin
          state <= DONE;
        end
      end else if (state == DUMPING && fe_vs) begin
        fcnt <= fcnt + ONE;
      end
    end
  end
endmodule

// File: tb/tb_mist_dump_window.sv
// tb_mist_dump_window: randomized scoreboard bench with a frame-level reference model.
module tb_mist_dump_window;
  localparam int CW = 4;
  localparam int SW = 2;
  localparam logic [15:0] LG = 16'd10;
  localparam int FM = 1 << CW;
  localparam int WMAX = (1 << SW) - 1;
  logic clk = 1'b0, rst = 1'b1, vs = 1'b0, led = 1'b0, cfg_deep = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [CW-1:0] cfg_start = '0, cfg_len = '0, cfg_period = '0;
  logic [CW-1:0] frame_cnt;
  logic dumping, dump_on, dump_off, dump_deep;
  logic [SW-1:0] win_cnt;
  mist_dump_window #(.CW(CW), .SW(SW), .LED_GUARD(LG)) dut (
    .clk(clk), .rst(rst), .vs(vs), .led(led), .cfg_mode(cfg_mode),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_period(cfg_period), .cfg_deep(cfg_deep),
    .frame_cnt(frame_cnt), .dumping(dumping), .dump_on(dump_on), .dump_off(dump_off),
    .dump_deep(dump_deep), .win_cnt(win_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit on;
    int fc;
    int wc;
    bit deep;
    int cyc;
  } ev_t;
  ev_t q[$];
  ev_t me;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int mf, m_wc, m_nxt, m_len, m_per, m_cnt, m_mode;
  bit m_armed, m_open, m_deep, d;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic push(input bit on, input int fc, input int wc, input bit deep, input int c);
    ev_t e;
    e.on = on;
    e.fc = fc % FM;
    e.wc = wc;
    e.deep = deep;
    e.cyc = c;
    q.push_back(e);
  endtask
  // monitor: every pulse must match the oldest expected event
  always @(posedge clk) begin
    #1;
    if (dump_on || dump_off) begin
      check("pulse_exclusive", dump_on & dump_off, 0);
      if (q.size() == 0) check("unexpected_pulse", {dump_on, dump_off}, 0);
      else begin
        me = q.pop_front();
        check("pulse_kind", dump_on, me.on);
        check("pulse_dumping", dumping, me.on);
        check("pulse_frame_cnt", frame_cnt, me.fc);
        check("pulse_win_cnt", win_cnt, me.wc);
        if (me.on) check("pulse_deep", dump_deep, me.deep);
        if (me.cyc >= 0) check("pulse_cycle", cyc, me.cyc);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic model_arm(input int mode, input int start, input int ln, input int pr, input bit deep, input int c);
    m_mode = mode;
    m_nxt = start % FM;
    m_len = ln;
    m_per = (pr != 0 && pr <= ln) ? 0 : pr;
    m_deep = deep;
    m_cnt = 0;
    m_armed = 1;
    m_open = 0;
    if (mode == 3) begin
      push(1, mf, m_wc, deep, c);
      m_open = 1;
    end
  endtask
  task automatic frame(input int hi, input int lo);
    if (m_open) begin
      m_cnt++;
      if (m_len != 0 && m_cnt == m_len) begin
        m_wc = m_wc < WMAX ? m_wc + 1 : WMAX;
        push(0, mf + 1, m_wc, 0, -1);
        m_open = 0;
        if (m_per != 0) begin
          m_nxt = (m_nxt + m_per) % FM;
          m_mode = 1;
        end else m_armed = 0;
      end
    end else if (m_armed && m_mode == 1 && mf == m_nxt) begin
      push(1, mf + 1, m_wc, m_deep, -1);
      m_open = 1;
      m_cnt = 0;
    end
    mf = (mf + 1) % FM;
    vs = 1'b1;
    tick(hi);
    vs = 1'b0;
    tick(lo);
  endtask
  task automatic rframes(input int n);
    repeat (n) frame($urandom_range(1, 3), $urandom_range(1, 4));
  endtask
  task automatic do_reset(input int mode, input int start, input int ln, input int pr, input bit deep);
    check("queue_drained", q.size(), 0);
    q.delete();
    rst = 1'b1;
    vs = 1'b0;
    led = 1'b0;
    cfg_mode = 2'(mode);
    cfg_start = CW'(start);
    cfg_len = CW'(ln);
    cfg_period = CW'(pr);
    cfg_deep = deep;
    tick(2);
    mf = 0;
    m_wc = 0;
    m_open = 0;
    m_armed = 0;
    if (mode != 0) model_arm(mode, start, ln, pr, deep, 2);
    rst = 1'b0;
  endtask
  task automatic disarm();
    if (m_open) push(0, mf, m_wc, 0, -1);
    m_open = 0;
    m_armed = 0;
    cfg_mode = 2'd0;
    tick(3);
  endtask
  task automatic status(input string tag);
    check({tag, "_frame_cnt"}, frame_cnt, mf);
    check({tag, "_win_cnt"}, win_cnt, m_wc);
    check({tag, "_dumping"}, dumping, m_open);
  endtask
  initial begin
    @(negedge clk);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_dumping", dumping, 0);
    check("rst_dump_on", dump_on, 0);
    check("rst_dump_off", dump_off, 0);
    check("rst_dump_deep", dump_deep, 0);
    check("rst_win_cnt", win_cnt, 0);
    do_reset(1, 5, 3, 0, 1);
    rframes(12);
    status("m1_single");
    disarm();
    do_reset(1, 2, 2, 4, 0);
    rframes(13);
    status("m1_period_three");
    rframes(7);
    status("m1_period_sat");
    disarm();
    do_reset(1, 2, 2, 2, 1);
    rframes(14);
    status("m1_forced_single");
    disarm();
    d = 1'($urandom_range(0, 1));
    do_reset(2, 0, 2, 0, d);
    led = 1'b1;
    tick(5);
    led = 1'b0;
    tick(5);
    led = 1'b1;
    tick(35);
    vs = 1'b1;
    tick(5);
    push(1, mf + 1, m_wc, d, 51);
    mf = (mf + 1) % FM;
    m_open = 1;
    m_cnt = 0;
    led = 1'b0;
    vs = 1'b0;
    tick(1);
    cfg_deep = ~d;
    tick(2);
    rframes(3);
    status("m2_led");
    check("m2_deep_held", dump_deep, d);
    disarm();
    d = 1'($urandom_range(0, 1));
    do_reset(3, 0, 0, 0, d);
    tick(3);
    repeat (1000) frame(1, 1);
    status("m3_unbounded");
    disarm();
    status("m3_off");
    do_reset(1, 14, 1, 3, 0);
    rframes(16);
    check("frame_wrap", frame_cnt, 0);
    rframes(6);
    status("m1_wrap");
    disarm();
    for (int r = 0; r < 4; r++) begin
      do_reset(1, $urandom_range(0, FM - 1), $urandom_range(0, 4), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      rframes(24);
      status("m1_rand");
      disarm();
      status("m1_rand_off");
    end
    do_reset(1, 1, 1, 2, 1);
    rframes(4);
    status("mid_pre");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_dumping", dumping, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_win_cnt", win_cnt, 0);
    check("mid_rst_dump_off", dump_off, 0);
    mf = 0;
    m_wc = 0;
    m_open = 0;
    m_armed = 0;
    @(negedge clk);
    tick(3);
    cfg_mode = 2'd0;
    rst = 1'b0;
    tick(3);
    check("final_queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
